sc_levelprogresstracker: RTL and testbench

Parametrised multi-level progress tracker for the RoadFighter game core. It counts road-advance strobes through a prescaler into a per-level progress value and detects level completion at a configurable target. It also sequences through NUM_LEVELS levels and flags game completion. Its outputs drive the progress bar and level display logic and the game-flow controller.

---
 rtl/sc_levelprogresstracker.sv | 203 ++++++++++++++++++++
 tb/tb_sc_levelprogresstracker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_levelprogresstracker.sv
// sc_levelprogresstracker
// Multi-level progress tracker for the RoadFighter game core.
// Road-advance strobes pass through a prescaler into a per-level progress
// counter. Reaching PROG_TARGET completes the level. After NUM_LEVELS levels
// the game is complete.
//
// Optional feature macro: CRASH_PENALTY_EN
//   defined   : a crash in RUN subtracts PENALTY from progress, clamping at 0.
//   undefined : the crash input is ignored and no subtractor is built.
//
// Handshake: there is no valid/ready pair. Every output is a plain register
// that updates on the clock edge after the input cycle that caused it.
// LevelDone is a one-cycle pulse. GameDone is a level that stays high while
// the FSM is in GAME_DONE.
module sc_levelprogresstracker #(
  parameter int PROG_WIDTH     = 5,
  parameter int PROG_TARGET    = 31,
  parameter int NUM_LEVELS     = 4,
  parameter int LEVEL_WIDTH    = 2,
  parameter int PRESCALE       = 1,
  parameter int PRESCALE_WIDTH = 4,
  parameter int PENALTY        = 4
) (
  input  logic                   SC_LEVELPROGRESSTRACKER_CLOCK_50,
  input  logic                   SC_LEVELPROGRESSTRACKER_RESET_InHigh,
  input  logic                   SC_LEVELPROGRESSTRACKER_Start_InLow,
  input  logic                   SC_LEVELPROGRESSTRACKER_CountSignal_InLow,
  input  logic                   SC_LEVELPROGRESSTRACKER_LevelRestart_InLow,
  input  logic                   SC_LEVELPROGRESSTRACKER_Pause_InHigh,
  input  logic                   SC_LEVELPROGRESSTRACKER_Crash_InHigh,
  output logic [PROG_WIDTH-1:0]  SC_LEVELPROGRESSTRACKER_Progress_OutBus,
  output logic [LEVEL_WIDTH-1:0] SC_LEVELPROGRESSTRACKER_Level_OutBus,
  output logic [1:0]             SC_LEVELPROGRESSTRACKER_State_OutBus,
  output logic                   SC_LEVELPROGRESSTRACKER_LevelDone_OutHigh,
  output logic                   SC_LEVELPROGRESSTRACKER_GameDone_OutHigh
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    LEVEL_WAIT = 2'd2,
    GAME_DONE  = 2'd3
  } state_t;

  // Parameter values cut down to the widths of the registers they meet.
  localparam int PRESC_LAST_I = PRESCALE - 1;
  localparam int LAST_LEVEL_I = NUM_LEVELS - 1;
  localparam logic [PROG_WIDTH-1:0]     TARGET_P   = PROG_TARGET[PROG_WIDTH-1:0];
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_LAST = PRESC_LAST_I[PRESCALE_WIDTH-1:0];
  localparam logic [LEVEL_WIDTH-1:0]    LAST_LEVEL = LAST_LEVEL_I[LEVEL_WIDTH-1:0];

  // Short local names for the ports.
  logic clk, rst;
  logic start_n, count_n, restart_n, pause, crash;
  assign clk       = SC_LEVELPROGRESSTRACKER_CLOCK_50;
  assign rst       = SC_LEVELPROGRESSTRACKER_RESET_InHigh;
  assign start_n   = SC_LEVELPROGRESSTRACKER_Start_InLow;
  assign count_n   = SC_LEVELPROGRESSTRACKER_CountSignal_InLow;
  assign restart_n = SC_LEVELPROGRESSTRACKER_LevelRestart_InLow;
  assign pause     = SC_LEVELPROGRESSTRACKER_Pause_InHigh;
  assign crash     = SC_LEVELPROGRESSTRACKER_Crash_InHigh;

  state_t                    state_q, state_d;
  logic [PROG_WIDTH-1:0]     progress_q, progress_d;
  logic [LEVEL_WIDTH-1:0]    level_q, level_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      level_done_q, level_done_d;
  logic                      game_done_q, game_done_d;
  logic                      start_hist_q, start_hist_d;

  // A start event is a high-to-low transition, so a held button acts once.
  logic start_ev;
  logic count_qual;
  logic [PROG_WIDTH-1:0] prog_inc;
  assign start_ev   = start_hist_q & ~start_n;
  assign count_qual = ~count_n & ~pause;
  // Only used in RUN, where progress is always below PROG_TARGET, so the
  // increment can neither exceed the target nor wrap.
  assign prog_inc   = progress_q + 1'b1;

`ifdef CRASH_PENALTY_EN
  // Saturating subtraction of the crash penalty, done at 32 bits so a
  // penalty wider than the progress counter still clamps to zero.
  logic [31:0]           prog_ext;
  logic [PROG_WIDTH-1:0] prog_crash;
  assign prog_ext   = 32'(progress_q);
  assign prog_crash = (prog_ext > 32'(PENALTY)) ?
                      PROG_WIDTH'(prog_ext - 32'(PENALTY)) : '0;
`else
  // Without the penalty feature the crash input and PENALTY are unused.
  localparam int unused_penalty = PENALTY;
  logic unused_crash;
  assign unused_crash = crash;
`endif

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      progress_q   <= '0;
      level_q      <= '0;
      presc_q      <= '0;
      level_done_q <= 1'b0;
      game_done_q  <= 1'b0;
      start_hist_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      progress_q   <= progress_d;
      level_q      <= level_d;
      presc_q      <= presc_d;
      level_done_q <= level_done_d;
      game_done_q  <= game_done_d;
      start_hist_q <= start_hist_d;
    end
  end

  // Next-state and datapath update; priority in RUN: restart, crash, count.
  always_comb begin
    state_d      = state_q;
    progress_d   = progress_q;
    level_d      = level_q;
    presc_d      = presc_q;
    level_done_d = 1'b0;
    start_hist_d = start_n;

    case (state_q)
      IDLE: begin
        progress_d = '0;
        level_d    = '0;
        presc_d    = '0;
        if (start_ev) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!restart_n) begin
          progress_d = '0;
          presc_d    = '0;
        end
`ifdef CRASH_PENALTY_EN
        else if (crash) begin
          progress_d = prog_crash;
          presc_d    = '0;
        end
`endif
        else if (count_qual) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (prog_inc == TARGET_P) begin
              progress_d   = TARGET_P;
              level_done_d = 1'b1;
              state_d      = (level_q == LAST_LEVEL) ? GAME_DONE : LEVEL_WAIT;
            end else begin
              progress_d = prog_inc;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      LEVEL_WAIT: begin
        progress_d = TARGET_P;
        if (!restart_n) begin
          // Replay the level just finished; level index is kept.
          progress_d = '0;
          presc_d    = '0;
          state_d    = RUN;
        end else if (start_ev) begin
          progress_d = '0;
          presc_d    = '0;
          level_d    = level_q + 1'b1;
          state_d    = RUN;
        end
      end

      GAME_DONE: begin
        progress_d = TARGET_P;
        level_d    = LAST_LEVEL;
        if (start_ev) begin
          progress_d = '0;
          level_d    = '0;
          presc_d    = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    game_done_d = (state_d == GAME_DONE);
  end

  assign SC_LEVELPROGRESSTRACKER_Progress_OutBus   = progress_q;
  assign SC_LEVELPROGRESSTRACKER_Level_OutBus      = level_q;
  assign SC_LEVELPROGRESSTRACKER_State_OutBus      = state_q;
  assign SC_LEVELPROGRESSTRACKER_LevelDone_OutHigh = level_done_q;
  assign SC_LEVELPROGRESSTRACKER_GameDone_OutHigh  = game_done_q;

endmodule

// File: tb/tb_sc_levelprogresstracker.sv
// Testbench for sc_levelprogresstracker.
// dut  : default parameters.
// dut3 : PRESCALE=3, PROG_TARGET=3, NUM_LEVELS=1.
// Expected output vectors are {state, level, progress, level_done, game_done}.
module tb_sc_levelprogresstracker;
  localparam int W = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic start_n, count_n, restart_n, pause, crash;
  logic start3_n, count3_n, restart3_n, pause3, crash3;

  logic [4:0] prog, prog3;
  logic [1:0] lvl, lvl3, st, st3;
  logic       ld, ld3, gd, gd3;

  sc_levelprogresstracker dut (
    .SC_LEVELPROGRESSTRACKER_CLOCK_50          (clk),
    .SC_LEVELPROGRESSTRACKER_RESET_InHigh      (rst),
    .SC_LEVELPROGRESSTRACKER_Start_InLow       (start_n),
    .SC_LEVELPROGRESSTRACKER_CountSignal_InLow (count_n),
    .SC_LEVELPROGRESSTRACKER_LevelRestart_InLow(restart_n),
    .SC_LEVELPROGRESSTRACKER_Pause_InHigh      (pause),
    .SC_LEVELPROGRESSTRACKER_Crash_InHigh      (crash),
    .SC_LEVELPROGRESSTRACKER_Progress_OutBus   (prog),
    .SC_LEVELPROGRESSTRACKER_Level_OutBus      (lvl),
    .SC_LEVELPROGRESSTRACKER_State_OutBus      (st),
    .SC_LEVELPROGRESSTRACKER_LevelDone_OutHigh (ld),
    .SC_LEVELPROGRESSTRACKER_GameDone_OutHigh  (gd)
  );

  sc_levelprogresstracker #(
    .PRESCALE(3), .PRESCALE_WIDTH(2), .PROG_TARGET(3), .NUM_LEVELS(1)
  ) dut3 (
    .SC_LEVELPROGRESSTRACKER_CLOCK_50          (clk),
    .SC_LEVELPROGRESSTRACKER_RESET_InHigh      (rst),
    .SC_LEVELPROGRESSTRACKER_Start_InLow       (start3_n),
    .SC_LEVELPROGRESSTRACKER_CountSignal_InLow (count3_n),
    .SC_LEVELPROGRESSTRACKER_LevelRestart_InLow(restart3_n),
    .SC_LEVELPROGRESSTRACKER_Pause_InHigh      (pause3),
    .SC_LEVELPROGRESSTRACKER_Crash_InHigh      (crash3),
    .SC_LEVELPROGRESSTRACKER_Progress_OutBus   (prog3),
    .SC_LEVELPROGRESSTRACKER_Level_OutBus      (lvl3),
    .SC_LEVELPROGRESSTRACKER_State_OutBus      (st3),
    .SC_LEVELPROGRESSTRACKER_LevelDone_OutHigh (ld3),
    .SC_LEVELPROGRESSTRACKER_GameDone_OutHigh  (gd3)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        nm_q[$];
  logic [W-1:0] exp3_q[$];
  string        nm3_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [W-1:0] pk(input int s, input int l, input int p,
                                      input int d, input int g);
    return {2'(s), 2'(l), 5'(p), 1'(d), 1'(g)};
  endfunction

  // Monitor: outputs are stable at the falling edge; compare pending entries.
  always @(negedge clk) begin
    logic [W-1:0] e, got;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      got = {st, lvl, prog, ld, gd};
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d lvl=%0d prog=%0d ld=%0d gd=%0d, want st=%0d lvl=%0d prog=%0d ld=%0d gd=%0d",
                 nm, got[10:9], got[8:7], got[6:2], got[1], got[0],
                 e[10:9], e[8:7], e[6:2], e[1], e[0]);
      end
    end
    if (exp3_q.size() > 0) begin
      e = exp3_q.pop_front();
      nm = nm3_q.pop_front();
      got = {st3, lvl3, prog3, ld3, gd3};
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got st=%0d lvl=%0d prog=%0d ld=%0d gd=%0d, want st=%0d lvl=%0d prog=%0d ld=%0d gd=%0d",
                 nm, got[10:9], got[8:7], got[6:2], got[1], got[0],
                 e[10:9], e[8:7], e[6:2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives inputs, waits one rising edge, queues
  // the expected post-edge outputs, and returns at the next falling edge.
  task automatic cyc(input logic s, input logic c, input logic r,
                     input logic p, input logic k, input bit chk,
                     input logic [W-1:0] e, input string nm);
    start_n = s; count_n = c; restart_n = r; pause = p; crash = k;
    @(posedge clk);
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(negedge clk);
  endtask

  task automatic cyc3(input logic s, input logic c, input logic p,
                      input bit chk, input logic [W-1:0] e, input string nm);
    start3_n = s; count3_n = c; pause3 = p;
    @(posedge clk);
    if (chk) begin
      exp3_q.push_back(e);
      nm3_q.push_back(nm);
    end
    @(negedge clk);
  endtask

  // Runs n qualified strobes on dut, checking only after the last one.
  task automatic count_n_strobes(input int n, input logic [W-1:0] e,
                                 input string nm);
    for (int i = 1; i <= n; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (i == n), e, nm);
    end
  endtask

  // ---------------- stimulus ----------------
  int pr3_tab[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 2};
  int crash1_pr, crash2_pr;

  initial begin
`ifdef CRASH_PENALTY_EN
    crash1_pr = 2; crash2_pr = 0;
`else
    crash1_pr = 7; crash2_pr = 8;
`endif
    rst = 1'b1;
    start_n = 1'b1; count_n = 1'b1; restart_n = 1'b1; pause = 1'b0; crash = 1'b0;
    start3_n = 1'b1; count3_n = 1'b1; restart3_n = 1'b1; pause3 = 1'b0; crash3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc(1, 1, 1, 0, 0, 1, pk(0, 0, 0, 0, 0), "reset_state");
    rst = 1'b0;

    // Level 0 step by step.
    cyc(0, 1, 1, 0, 0, 1, pk(1, 0, 0, 0, 0), "start_from_idle");
    for (int i = 1; i <= 31; i++) begin
      cyc(1, 0, 1, 0, 0, 1, (i == 31) ? pk(2, 0, 31, 1, 0) : pk(1, 0, i, 0, 0),
          "count_level0");
    end
    cyc(1, 0, 1, 0, 0, 1, pk(2, 0, 31, 0, 0), "level_wait_hold");

    // Levels 1..3, game completion.
    for (int l = 1; l <= 3; l++) begin
      cyc(0, 1, 1, 0, 0, 1, pk(1, l, 0, 0, 0), "next_level");
      count_n_strobes(31, (l == 3) ? pk(3, 3, 31, 1, 1) : pk(2, l, 31, 1, 0),
                      "level_complete");
    end
    cyc(1, 0, 1, 0, 0, 1, pk(3, 3, 31, 0, 1), "game_done_hold");
    cyc(0, 1, 1, 0, 0, 1, pk(0, 0, 0, 0, 0), "game_done_to_idle");
    cyc(0, 1, 1, 0, 0, 1, pk(0, 0, 0, 0, 0), "held_start_idle");
    cyc(1, 1, 1, 0, 0, 0, '0, "");

    // Restart, pause and crash in RUN.
    cyc(0, 1, 1, 0, 0, 1, pk(1, 0, 0, 0, 0), "restart_game");
    count_n_strobes(10, pk(1, 0, 10, 0, 0), "count_to_10");
    cyc(1, 0, 0, 0, 0, 1, pk(1, 0, 0, 0, 0), "restart_beats_count");
    cyc(1, 0, 1, 1, 0, 1, pk(1, 0, 0, 0, 0), "pause_freezes");
    count_n_strobes(6, pk(1, 0, 6, 0, 0), "count_to_6");
    cyc(1, 0, 1, 0, 1, 1, pk(1, 0, crash1_pr, 0, 0), "crash_first");
    cyc(1, 0, 1, 0, 1, 1, pk(1, 0, crash2_pr, 0, 0), "crash_second");

    // Restart from LEVEL_WAIT, then reach level 2 progress 17.
    cyc(1, 1, 0, 0, 0, 1, pk(1, 0, 0, 0, 0), "restart_run2");
    count_n_strobes(31, pk(2, 0, 31, 1, 0), "level0_again");
    cyc(1, 1, 0, 0, 0, 1, pk(1, 0, 0, 0, 0), "restart_level_wait");
    count_n_strobes(31, pk(2, 0, 31, 1, 0), "level0_replay");
    cyc(0, 1, 1, 0, 0, 1, pk(1, 1, 0, 0, 0), "to_level1");
    count_n_strobes(31, pk(2, 1, 31, 1, 0), "level1_done");
    cyc(0, 1, 1, 0, 0, 1, pk(1, 2, 0, 0, 0), "to_level2");
    count_n_strobes(17, pk(1, 2, 17, 0, 0), "level2_at_17");

    // Asynchronous reset between edges: checked at the falling edge before
    // any further rising edge has occurred.
    start_n = 1'b1; count_n = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0));
    nm_q.push_back("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0), "ignored_in_idle");

    // Prescaled instance: pause on strobes 4..6.
    cyc3(0, 1, 0, 1, pk(1, 0, 0, 0, 0), "p3_start");
    for (int i = 1; i <= 9; i++) begin
      cyc3(1, 0, (i >= 4 && i <= 6), 1, pk(1, 0, pr3_tab[i-1], 0, 0), "p3_prescale");
    end
    cyc3(1, 0, 0, 1, pk(1, 0, 2, 0, 0), "p3_presc_cleared_a");
    cyc3(1, 0, 0, 1, pk(1, 0, 2, 0, 0), "p3_presc_cleared_b");
    cyc3(1, 0, 0, 1, pk(3, 0, 3, 1, 1), "p3_single_level_game_done");
    for (int i = 1; i <= 20; i++) begin
      cyc3(0, 1, 0, 1, pk(0, 0, 0, 0, 0), "p3_held_start_once");
    end
    cyc3(1, 1, 0, 0, '0, "");

    // Drain the scoreboard (bounded).
    for (int t = 0; t < 10 && (exp_q.size() > 0 || exp3_q.size() > 0); t++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0 || exp3_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size() + exp3_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
